// File: rtl/vc_buffer.sv
`default_nettype none
// ============================================================================
// Module : vc_buffer
// Desc   : Per-VC flit FIFOs sharing one write and one read port, with credit
//          return and overflow/underflow pulses. Define VC_BUFFER_FWFT_EN for
//          first-word-fall-through reads; default is a registered read port.
// Rev    : 1.0
// ============================================================================
module vc_buffer #(
    parameter int NUM_BITS = 8,
    parameter int DEPTH    = 4,
    parameter int NUM_VC   = 2,
    localparam int VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [VCW-1:0]       wr_vc,
    input  logic [NUM_BITS-1:0]  fifo_in,
    input  logic                 rd_en,
    input  logic [VCW-1:0]       rd_vc,
    output logic [NUM_BITS-1:0]  fifo_out,
    output logic                 out_valid,
    output logic [NUM_VC-1:0]    empty,
    output logic [NUM_VC-1:0]    full,
    output logic [NUM_VC*CW-1:0] fifo_counter,
    output logic [NUM_VC-1:0]    credit_out,
    output logic                 ovf_err,
    output logic                 udf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [VCW:0] c_vc_limit = (VCW + 1)'(NUM_VC);
    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);

    logic [NUM_BITS-1:0] r_mem   [NUM_VC][DEPTH];
    logic [AW-1:0]       r_wptr  [NUM_VC];
    logic [AW-1:0]       r_rptr  [NUM_VC];
    logic [CW-1:0]       r_count [NUM_VC];

    logic                w_wr_vc_ok;
    logic                w_rd_vc_ok;
    logic [VCW-1:0]      w_wr_idx;
    logic [VCW-1:0]      w_rd_idx;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic [NUM_VC-1:0]   w_wr_sel;
    logic [NUM_VC-1:0]   w_rd_sel;
    logic [NUM_BITS-1:0] w_head;

    // Out-of-range VC ids are steered to VC 0 for indexing only; the
    // range flag keeps them from being accepted.
    assign w_wr_vc_ok = ({1'b0, wr_vc} < c_vc_limit);
    assign w_rd_vc_ok = ({1'b0, rd_vc} < c_vc_limit);
    assign w_wr_idx   = w_wr_vc_ok ? wr_vc : '0;
    assign w_rd_idx   = w_rd_vc_ok ? rd_vc : '0;
    assign w_wr_ok    = wr_en && w_wr_vc_ok && !full[w_wr_idx];
    assign w_rd_ok    = rd_en && w_rd_vc_ok && !empty[w_rd_idx];
    assign w_head     = r_mem[w_rd_idx][r_rptr[w_rd_idx]];

    always_comb begin
        empty        = '0;
        full         = '0;
        fifo_counter = '0;
        w_wr_sel     = '0;
        w_rd_sel     = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            empty[i]                 = (r_count[i] == '0);
            full[i]                  = (r_count[i] == c_depth);
            fifo_counter[i*CW +: CW] = r_count[i];
        end
        if (w_wr_ok) w_wr_sel[w_wr_idx] = 1'b1;
        if (w_rd_ok) w_rd_sel[w_rd_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_count[i] <= '0;
            end
            credit_out <= '0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (w_wr_sel[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_rd_sel[i]) r_rptr[i] <= r_rptr[i] + 1'b1;
                // A same-cycle write and read on one VC leaves the count alone.
                if (w_wr_sel[i] && !w_rd_sel[i])
                    r_count[i] <= r_count[i] + 1'b1;
                else if (!w_wr_sel[i] && w_rd_sel[i])
                    r_count[i] <= r_count[i] - 1'b1;
            end
            credit_out <= w_rd_sel;
            ovf_err    <= wr_en && !w_wr_ok;
            udf_err    <= rd_en && !w_rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[w_wr_idx][r_wptr[w_wr_idx]] <= fifo_in;
    end

`ifdef VC_BUFFER_FWFT_EN
    assign out_valid = w_rd_vc_ok && !empty[w_rd_idx];
    assign fifo_out  = out_valid ? w_head : '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= w_rd_ok;
            if (w_rd_ok) fifo_out <= w_head;
        end
    end
`endif

endmodule
`default_nettype wire
